// File: rtl/idli_sqi_mem_m.sv
// Quad-SPI SRAM responder (23LC1024-style sequential READ/WRITE) backed by an
// internal byte array; the SQI pins are oversampled on the local clock.
module idli_sqi_mem_m #(
  parameter int MEM_BYTES = 256,
  parameter int ADDR_W    = 8
) (
  input  logic       i_mem_gck,
  input  logic       i_mem_rst_n,
  input  logic       i_mem_sqi_sck,
  input  logic       i_mem_sqi_cs,
  input  logic [3:0] i_mem_sqi_data,
  output logic [3:0] o_mem_sqi_data,
  output logic       o_mem_sqi_oe,
  output logic       o_mem_err
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_ERR
  } state_t;

  logic [2:0]        sck_sync;
  logic [1:0]        cs_sync;
  logic [3:0]        data_s1;
  logic [3:0]        data_s2;
  logic              sck_rise;
  logic              sck_fall;
  logic              cs_high;

  state_t            state_q,   state_d;
  logic [2:0]        cnt_q,     cnt_d;
  logic [3:0]        cmd_q,     cmd_d;
  logic [23:0]       addr_q,    addr_d;
  logic [ADDR_W-1:0] ptr_q,     ptr_d;
  logic              is_read_q, is_read_d;
  logic [3:0]        wr_hi_q,   wr_hi_d;
  logic [3:0]        dout_q,    dout_d;
  logic              oe_q,      oe_d;
  logic              err_q,     err_d;

  logic              wr_en;
  logic [7:0]        wr_byte;
  logic [7:0]        rd_byte;

  logic [7:0]        mem [MEM_BYTES];

  // Two-flop synchronisers; the third sck flop gives the edge reference.
  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      sck_sync <= 3'b000;
      cs_sync  <= 2'b11;
      data_s1  <= 4'h0;
      data_s2  <= 4'h0;
    end else begin
      sck_sync <= {sck_sync[1:0], i_mem_sqi_sck};
      cs_sync  <= {cs_sync[0], i_mem_sqi_cs};
      data_s1  <= i_mem_sqi_data;
      data_s2  <= data_s1;
    end
  end

  assign sck_rise = sck_sync[1] & ~sck_sync[2];
  assign sck_fall = ~sck_sync[1] & sck_sync[2];
  assign cs_high  = cs_sync[1];

  assign rd_byte  = mem[ptr_q];
  assign wr_byte  = {wr_hi_q, data_s2};

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 3'd0;
      cmd_q     <= 4'h0;
      addr_q    <= 24'h0;
      ptr_q     <= '0;
      is_read_q <= 1'b0;
      wr_hi_q   <= 4'h0;
      dout_q    <= 4'h0;
      oe_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      is_read_q <= is_read_d;
      wr_hi_q   <= wr_hi_d;
      dout_q    <= dout_d;
      oe_q      <= oe_d;
      err_q     <= err_d;
    end
  end

  // cnt_q counts command/address/dummy nibbles, and doubles as the hi/lo
  // selector while streaming data bytes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    ptr_d     = ptr_q;
    is_read_d = is_read_q;
    wr_hi_d   = wr_hi_q;
    dout_d    = dout_q;
    oe_d      = 1'b0;
    err_d     = 1'b0;
    wr_en     = 1'b0;

    if (cs_high) begin
      state_d = ST_IDLE;
      cnt_d   = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_CMD;
          cnt_d   = 3'd0;
        end

        ST_CMD: begin
          if (sck_rise) begin
            if (cnt_q == 3'd0) begin
              cmd_d = data_s2;
              cnt_d = 3'd1;
            end else begin
              cnt_d = 3'd0;
              case ({cmd_q, data_s2})
                8'h03: begin
                  is_read_d = 1'b1;
                  state_d   = ST_ADDR;
                end
                8'h02: begin
                  is_read_d = 1'b0;
                  state_d   = ST_ADDR;
                end
                default: begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
                end
              endcase
            end
          end
        end

        ST_ADDR: begin
          if (sck_rise) begin
            addr_d = 24'({addr_q, data_s2});
            if (cnt_q == 3'd5) begin
              cnt_d   = 3'd0;
              ptr_d   = addr_d[ADDR_W-1:0];
              state_d = is_read_q ? ST_DUMMY : ST_WR_DATA;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end

        ST_DUMMY: begin
          if (sck_rise) begin
            if (cnt_q == 3'd1) begin
              cnt_d   = 3'd0;
              state_d = ST_RD_DATA;
            end else begin
              cnt_d = 3'd1;
            end
          end
        end

        // Drive on the falling edge so the nibble is settled for the rise.
        ST_RD_DATA: begin
          oe_d = oe_q;
          if (sck_fall) begin
            oe_d = 1'b1;
            if (cnt_q == 3'd0) begin
              dout_d = rd_byte[7:4];
              cnt_d  = 3'd1;
            end else begin
              dout_d = rd_byte[3:0];
              cnt_d  = 3'd0;
              ptr_d  = ptr_q + 1'b1;
            end
          end
        end

        ST_WR_DATA: begin
          if (sck_rise) begin
            if (cnt_q == 3'd0) begin
              wr_hi_d = data_s2;
              cnt_d   = 3'd1;
            end else begin
              wr_en = 1'b1;
              cnt_d = 3'd0;
              ptr_d = ptr_q + 1'b1;
            end
          end
        end

        ST_ERR: begin
          state_d = ST_ERR;
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  // Storage is deliberately left without reset.
  always_ff @(posedge i_mem_gck) begin
    if (wr_en) begin
      mem[ptr_q] <= wr_byte;
    end
  end

  assign o_mem_sqi_data = dout_q;
  assign o_mem_sqi_oe   = oe_q;
  assign o_mem_err      = err_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Self-checking bench for idli_sqi_mem_m: acts as the SQI initiator and keeps
// a byte-array model, queueing expected read nibbles for comparison.
module tb_idli_sqi_mem_m;

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       cs;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       oe;
  logic       err;

  int         n_checks;
  int         n_fails;
  int         err_cnt;
  int         oe_cnt;

  logic [7:0] model [256];
  logic [3:0] exp_q [$];

  idli_sqi_mem_m #(
    .MEM_BYTES(256),
    .ADDR_W   (8)
  ) dut (
    .i_mem_gck     (clk),
    .i_mem_rst_n   (rst_n),
    .i_mem_sqi_sck (sck),
    .i_mem_sqi_cs  (cs),
    .i_mem_sqi_data(data_in),
    .o_mem_sqi_data(data_out),
    .o_mem_sqi_oe  (oe),
    .o_mem_err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (err) err_cnt++;
    if (oe)  oe_cnt++;
  end

  task automatic sck_cycle(input logic [3:0] n);
    data_in = n;
    repeat (4) @(negedge clk);
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic bus_start();
    cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_end();
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr);
    sck_cycle(cmd[7:4]);
    sck_cycle(cmd[3:0]);
    for (int i = 5; i >= 0; i--) sck_cycle(addr[i*4 +: 4]);
  endtask

  task automatic do_write(input logic [23:0] addr, input logic [7:0] b0,
                          input logic [7:0] b1, input int nbytes);
    logic [7:0] b;
    bus_start();
    send_header(8'h02, addr);
    for (int i = 0; i < nbytes; i++) begin
      b = (i == 0) ? b0 : b1;
      sck_cycle(b[7:4]);
      sck_cycle(b[3:0]);
      model[addr[7:0] + 8'(i)] = b;
    end
    bus_end();
  endtask

  task automatic do_read(input logic [23:0] addr, input int nbytes, input string tag);
    logic [7:0] b;
    logic [3:0] exp;
    bus_start();
    send_header(8'h03, addr);
    sck_cycle(4'h0);
    sck_cycle(4'h0);
    n_checks++;
    if (oe !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL %s pre_drive_oe: got %b want 0", tag, oe);
    end
    for (int i = 0; i < nbytes; i++) begin
      b = model[addr[7:0] + 8'(i)];
      exp_q.push_back(b[7:4]);
      exp_q.push_back(b[3:0]);
    end
    for (int j = 0; j < 2 * nbytes; j++) begin
      data_in = 4'h0;
      repeat (4) @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (oe !== 1'b1) begin
        n_fails++;
        $display("[TB] FAIL %s oe[%0d]: got %b want 1", tag, j, oe);
      end
      n_checks++;
      if (data_out !== exp) begin
        n_fails++;
        $display("[TB] FAIL %s nibble[%0d]: got %h want %h", tag, j, data_out, exp);
      end
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    bus_end();
    n_checks++;
    if (oe !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL %s oe_after_cs: got %b want 0", tag, oe);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (oe !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_oe: got %b want 0", oe);
    end
    n_checks++;
    if (data_out !== 4'h0) begin
      n_fails++;
      $display("[TB] FAIL reset_data: got %h want 0", data_out);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_err: got %b want 0", err);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_read();
    do_write(24'h000010, 8'hA5, 8'h3C, 2);
    do_read(24'h000010, 2, "write_read");
  endtask

  task automatic test_wrap();
    do_write(24'h0000FF, 8'h11, 8'h22, 2);
    do_read(24'h0000FF, 2, "wrap");
    do_read(24'h000000, 1, "wrap_mem0");
  endtask

  task automatic test_alias();
    do_write(24'h012345, 8'h77, 8'h00, 1);
    do_read(24'h000045, 1, "alias");
  endtask

  task automatic test_bad_cmd();
    int err_before;
    int oe_before;
    bus_start();
    err_before = err_cnt;
    oe_before  = oe_cnt;
    sck_cycle(4'h9);
    sck_cycle(4'hF);
    for (int i = 0; i < 6; i++) sck_cycle(4'h3);
    n_checks++;
    if (err_cnt - err_before != 1) begin
      n_fails++;
      $display("[TB] FAIL bad_cmd_err_width: got %0d cycles want 1", err_cnt - err_before);
    end
    n_checks++;
    if (oe_cnt != oe_before) begin
      n_fails++;
      $display("[TB] FAIL bad_cmd_oe: got %0d oe cycles want 0", oe_cnt - oe_before);
    end
    bus_end();
    do_read(24'h000010, 1, "after_bad_cmd");
  endtask

  task automatic test_abort();
    do_write(24'h000020, 8'h5A, 8'h66, 2);
    // Write aborted after the hi nibble only.
    bus_start();
    send_header(8'h02, 24'h000020);
    sck_cycle(4'hF);
    bus_end();
    // cs rise coinciding with the lo-nibble sck rise.
    bus_start();
    send_header(8'h02, 24'h000021);
    sck_cycle(4'hE);
    data_in = 4'h1;
    repeat (4) @(negedge clk);
    cs  = 1'b1;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (6) @(negedge clk);
    do_read(24'h000020, 2, "abort");
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] b;
    int         oe_before;
    b = model[8'h10];
    bus_start();
    send_header(8'h03, 24'h000010);
    sck_cycle(4'h0);
    sck_cycle(4'h0);
    repeat (4) @(negedge clk);
    n_checks++;
    if (data_out !== b[7:4] || oe !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL mid_read_hi: got oe=%b data=%h want oe=1 data=%h", oe, data_out, b[7:4]);
    end
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (oe !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL mid_read_reset_oe: got %b want 0", oe);
    end
    n_checks++;
    if (data_out !== 4'h0) begin
      n_fails++;
      $display("[TB] FAIL mid_read_reset_data: got %h want 0", data_out);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    oe_before = oe_cnt;
    for (int i = 0; i < 6; i++) sck_cycle(4'h0);
    n_checks++;
    if (oe_cnt != oe_before) begin
      n_fails++;
      $display("[TB] FAIL mid_read_no_drive: got %0d oe cycles want 0", oe_cnt - oe_before);
    end
    bus_end();
    do_read(24'h000010, 1, "after_mid_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    err_cnt  = 0;
    oe_cnt   = 0;
    cs       = 1'b1;
    sck      = 1'b0;
    data_in  = 4'h0;
    rst_n    = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;

    test_reset();
    test_write_read();
    test_wrap();
    test_alias();
    test_bad_cmd();
    test_abort();
    test_reset_mid_read();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
